rbm_vote_accumulator: RTL and testbench

//  Iteration controller for stochastic RBM inference. Repeatedly restarts the hidden/classify

---
 rtl/rbm_vote_accumulator.sv | 181 ++++++++++++++++++
 tb/tb_rbm_vote_accumulator.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbm_vote_accumulator.sv
// Iteration controller for stochastic RBM inference: restarts the layer chain, accumulates
// saturated per-class votes, and reports the sums, the winning class and the iteration count.
module rbm_vote_accumulator #(
    parameter int                   bitlength  = 12,
    parameter int                   output_dim = 2,
    parameter int                   iter_width = 16,
    parameter logic [bitlength-1:0] Inf        = {1'b0, {(bitlength-1){1'b1}}},
    parameter int                   idx_width  = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [iter_width-1:0]            iter_num,
    input  logic [bitlength-1:0]             margin,
    input  logic                             sample_valid,
    input  logic [output_dim*bitlength-1:0]  SampleData,
    output logic                             layer_reset,
    output logic                             busy,
    output logic [output_dim*bitlength-1:0]  OutputData,
    output logic [idx_width-1:0]             winner,
    output logic [iter_width-1:0]            iter_count,
    output logic                             early_stop,
    output logic                             finish
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT,
        ST_ACCUM,
        ST_DONE
    } state_t;

    typedef logic signed [bitlength-1:0] lane_t;
    typedef logic signed [bitlength:0]   wide_t;

    localparam wide_t POS_LIM  = wide_t'({1'b0, Inf});
    localparam wide_t NEG_LIM  = -POS_LIM;
    localparam wide_t WIDE_MIN = {1'b1, {bitlength{1'b0}}};

    state_t                 state_q, state_d;
    lane_t                  acc_q [output_dim];
    lane_t                  acc_d [output_dim];
    logic [iter_width-1:0]  cnt_q, cnt_d;
    logic [iter_width-1:0]  num_q, num_d;
    logic [bitlength-1:0]   margin_q, margin_d;
    logic [idx_width-1:0]   winner_q, winner_d;
    logic                   early_q, early_d;

    // Saturating per-lane add, one bit wider so the overflow is visible before clamping.
    wide_t raw_sum [output_dim];
    lane_t sat_sum [output_dim];

    always_comb begin
        for (int g = 0; g < output_dim; g++) begin
            raw_sum[g] = wide_t'(acc_q[g]) + wide_t'($signed(SampleData[g*bitlength +: bitlength]));
            if (raw_sum[g] > POS_LIM) begin
                sat_sum[g] = lane_t'(POS_LIM);
            end else if (raw_sum[g] < NEG_LIM) begin
                sat_sum[g] = lane_t'(NEG_LIM);
            end else begin
                sat_sum[g] = lane_t'(raw_sum[g]);
            end
        end
    end

    // Leader and runner-up; strict compares keep the lower index on ties.
    logic [idx_width-1:0] top_idx;
    wide_t                top_val;
    wide_t                sec_val;
    wide_t                lead;

    always_comb begin
        top_idx = '0;
        top_val = wide_t'(acc_q[0]);
        sec_val = WIDE_MIN;
        for (int g = 1; g < output_dim; g++) begin
            if (wide_t'(acc_q[g]) > top_val) begin
                sec_val = top_val;
                top_val = wide_t'(acc_q[g]);
                top_idx = idx_width'(g);
            end else if (wide_t'(acc_q[g]) > sec_val) begin
                sec_val = wide_t'(acc_q[g]);
            end
        end
        lead = top_val - sec_val;
    end

    logic count_hit;
    logic margin_hit;

    assign count_hit  = (cnt_q == num_q);
    assign margin_hit = (margin_q != '0) && (lead >= wide_t'({1'b0, margin_q}));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        num_d    = num_q;
        margin_d = margin_q;
        winner_d = winner_q;
        early_d  = early_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_d    = iter_num;
                    margin_d = margin;
                    for (int g = 0; g < output_dim; g++) begin
                        acc_d[g] = '0;
                    end
                    cnt_d    = '0;
                    winner_d = '0;
                    early_d  = 1'b0;
                    state_d  = (iter_num == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sample_valid) begin
                    acc_d = sat_sum;
                    if (cnt_q != {iter_width{1'b1}}) begin
                        cnt_d = cnt_q + iter_width'(1);
                    end
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (count_hit || margin_hit) begin
                    winner_d = top_idx;
                    early_d  = !count_hit;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same
    // pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            for (int g = 0; g < output_dim; g++) begin
                acc_q[g] <= '0;
            end
            cnt_q    <= '0;
            num_q    <= '0;
            margin_q <= '0;
            winner_q <= '0;
            early_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            margin_q <= margin_d;
            winner_q <= winner_d;
            early_q  <= early_d;
        end
    end

    for (genvar g = 0; g < output_dim; g++) begin : g_pack
        assign OutputData[g*bitlength +: bitlength] = acc_q[g];
    end

    assign layer_reset = reset | (state_q == ST_CLEAR);
    assign busy        = (state_q == ST_CLEAR) || (state_q == ST_WAIT) || (state_q == ST_ACCUM);
    assign finish      = (state_q == ST_DONE);
    assign winner      = winner_q;
    assign iter_count  = cnt_q;
    assign early_stop  = early_q;

endmodule

// File: tb/tb_rbm_vote_accumulator.sv
// Scoreboard bench for rbm_vote_accumulator: directed runs with hand-derived results plus
// randomized runs checked against a plain-arithmetic reference model.
module tb_rbm_vote_accumulator;

    localparam int BL   = 12;
    localparam int DIM  = 3;
    localparam int ITW  = 16;
    localparam int IDXW = 2;
    localparam int DW   = DIM * BL;
    localparam int INF  = 2047;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [ITW-1:0]  iter_num = '0;
    logic [BL-1:0]   margin = '0;
    logic            sample_valid = 1'b0;
    logic [DW-1:0]   SampleData = '0;
    logic            layer_reset;
    logic            busy;
    logic [DW-1:0]   OutputData;
    logic [IDXW-1:0] winner;
    logic [ITW-1:0]  iter_count;
    logic            early_stop;
    logic            finish;

    rbm_vote_accumulator #(
        .bitlength  (BL),
        .output_dim (DIM),
        .iter_width (ITW),
        .Inf        (12'h7FF),
        .idx_width  (IDXW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .iter_num     (iter_num),
        .margin       (margin),
        .sample_valid (sample_valid),
        .SampleData   (SampleData),
        .layer_reset  (layer_reset),
        .busy         (busy),
        .OutputData   (OutputData),
        .winner       (winner),
        .iter_count   (iter_count),
        .early_stop   (early_stop),
        .finish       (finish)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [IDXW-1:0] win;
        logic [ITW-1:0]  cnt;
        logic            early;
        int              pulses;
        int              cycles;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] samp_q [$];
    int            lat_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pack3(input int a, input int b, input int c);
        logic [DW-1:0] p;
        p[0 +: BL]    = BL'(a);
        p[BL +: BL]   = BL'(b);
        p[2*BL +: BL] = BL'(c);
        return p;
    endfunction

    function automatic exp_t mk_exp(input logic [DW-1:0] d, input int w, input int c,
                                    input bit e, input int p, input int cyc);
        exp_t x;
        x.data   = d;
        x.win    = IDXW'(w);
        x.cnt    = ITW'(c);
        x.early  = e;
        x.pulses = p;
        x.cycles = cyc;
        return x;
    endfunction

    // Reference: run the vote loop on integers, clamping each sum to +/-INF.
    function automatic exp_t model(input int n, input int mgn);
        int            acc [DIM];
        int            best;
        int            second;
        int            cnt;
        int            cyc;
        bit            early;
        logic [DW-1:0] s;
        for (int g = 0; g < DIM; g++) acc[g] = 0;
        best = 0; cnt = 0; cyc = 1; early = 1'b0;
        for (int k = 0; k < n; k++) begin
            s = samp_q[k];
            for (int g = 0; g < DIM; g++) begin
                acc[g] = acc[g] + int'($signed(s[g*BL +: BL]));
                if (acc[g] > INF) acc[g] = INF;
                else if (acc[g] < -INF) acc[g] = -INF;
            end
            cnt++;
            cyc += 3 + lat_q[k];
            best = 0;
            for (int g = 1; g < DIM; g++) if (acc[g] > acc[best]) best = g;
            second = -(1 << 30);
            for (int g = 0; g < DIM; g++) if (g != best && acc[g] > second) second = acc[g];
            if (cnt == n) break;
            if (mgn != 0 && acc[best] - second >= mgn) begin
                early = 1'b1;
                break;
            end
        end
        return mk_exp(pack3(acc[0], acc[1], acc[2]), best, cnt, early, cnt, cyc);
    endfunction

    function automatic int rand_lane();
        int v;
        if ($urandom_range(0, 7) == 0) begin
            v = int'($urandom_range(1024, 2047));
            if ($urandom_range(0, 1) == 1) v = -v;
        end else begin
            v = int'($urandom_range(0, 40)) - 20;
        end
        return v;
    endfunction

    task automatic fill(input logic [DW-1:0] s, input int count);
        samp_q.delete();
        lat_q.delete();
        repeat (count) begin
            samp_q.push_back(s);
            lat_q.push_back(0);
        end
    endtask

    task automatic drive_noise(input bit noisy);
        sample_valid = noisy & 1'($urandom_range(0, 1));
        start        = noisy & 1'($urandom_range(0, 1));
        SampleData   = DW'({$urandom(), $urandom()});
        iter_num     = ITW'($urandom());
    endtask

    // Starts a run and answers each layer restart with the next queued sample; called and
    // returns at 1 time unit after a rising edge.
    task automatic do_run(input int n, input int mgn, input bit noisy);
        int k;
        int guard;
        int lat;
        k = 0;
        guard = 0;
        iter_num = ITW'(n);
        margin   = BL'(mgn);
        start    = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        iter_num = ITW'($urandom());
        margin   = BL'($urandom());
        while (!finish && guard < 2000) begin
            if (layer_reset) begin
                drive_noise(noisy);
                @(posedge clock); #1;
                sample_valid = 1'b0;
                start        = 1'b0;
                lat = (k < lat_q.size()) ? lat_q[k] : 0;
                for (int d = 0; d < lat; d++) begin
                    start    = noisy & 1'($urandom_range(0, 1));
                    iter_num = ITW'($urandom());
                    @(posedge clock); #1;
                end
                start        = noisy & 1'($urandom_range(0, 1));
                sample_valid = 1'b1;
                SampleData   = (k < samp_q.size()) ? samp_q[k] : '0;
                @(posedge clock); #1;
                k++;
                drive_noise(noisy);
                @(posedge clock); #1;
                sample_valid = 1'b0;
                start        = 1'b0;
                guard += 3 + lat;
            end else begin
                @(posedge clock); #1;
                guard++;
            end
        end
        sample_valid = 1'b0;
        start        = 1'b0;
        if (!finish) check("run_timeout", 0, 1);
    endtask

    // Monitor: measures each run from accepted start to finish and checks it against the queue.
    initial begin : monitor
        bit   run_open;
        int   cyc;
        int   pulses;
        exp_t e;
        run_open = 1'b0;
        cyc = 0;
        pulses = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                run_open = 1'b0;
            end else begin
                if (run_open) begin
                    cyc++;
                    if (layer_reset) pulses++;
                    if (finish) begin
                        run_open = 1'b0;
                        if (exp_q.size() == 0) begin
                            check("unexpected_finish", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            for (int g = 0; g < DIM; g++) begin
                                check($sformatf("out_lane%0d", g),
                                      longint'($signed(OutputData[g*BL +: BL])),
                                      longint'($signed(e.data[g*BL +: BL])));
                            end
                            check("winner", longint'(winner), longint'(e.win));
                            check("iter_count", longint'(iter_count), longint'(e.cnt));
                            check("early_stop", longint'(early_stop), longint'(e.early));
                            check("layer_reset_pulses", longint'(pulses), longint'(e.pulses));
                            check("start_to_finish", longint'(cyc), longint'(e.cycles));
                        end
                    end
                end
                if (start && !busy) begin
                    run_open = 1'b1;
                    cyc = 0;
                    pulses = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int mgn;
        int idle;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_layer_reset", longint'(layer_reset), 1);
        check("rst_output", longint'(OutputData), 0);
        check("rst_winner", longint'(winner), 0);
        check("rst_iter_count", longint'(iter_count), 0);
        check("rst_early_stop", longint'(early_stop), 0);
        check("rst_finish", longint'(finish), 0);
        check("rst_busy", longint'(busy), 0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_layer_reset", longint'(layer_reset), 0);

        // Samples offered while idle are ignored
        sample_valid = 1'b1;
        repeat (3) begin
            SampleData = DW'({$urandom(), $urandom()});
            @(posedge clock); #1;
        end
        sample_valid = 1'b0;
        check("idle_sample_output", longint'(OutputData), 0);
        check("idle_sample_count", longint'(iter_count), 0);
        check("idle_sample_busy", longint'(busy), 0);

        // T1: count-limited run
        samp_q.delete(); lat_q.delete();
        samp_q.push_back(pack3(1, 0, 0)); lat_q.push_back(0);
        samp_q.push_back(pack3(1, 0, 0)); lat_q.push_back(0);
        samp_q.push_back(pack3(0, 1, 0)); lat_q.push_back(0);
        exp_q.push_back(mk_exp(pack3(2, 1, 0), 0, 3, 1'b0, 3, 10));
        do_run(3, 0, 1'b0);

        // T2: margin early stop
        fill(pack3(1, 0, 0), 100);
        exp_q.push_back(mk_exp(pack3(3, 0, 0), 0, 3, 1'b1, 3, 10));
        do_run(100, 3, 1'b1);

        // T3: saturation without sign flip
        fill(pack3(12'h600, -12'h600, 0), 4);
        exp_q.push_back(mk_exp(pack3(2047, -2047, 0), 0, 4, 1'b0, 4, 13));
        do_run(4, 0, 1'b1);

        // T4: tie goes to the lower index, then a zero-length restart from DONE
        fill(pack3(2, 5, 5), 1);
        exp_q.push_back(mk_exp(pack3(2, 5, 5), 1, 1, 1'b0, 1, 4));
        do_run(1, 0, 1'b0);
        fill(pack3(0, 0, 0), 0);
        exp_q.push_back(mk_exp(pack3(0, 0, 0), 0, 0, 1'b0, 0, 1));
        do_run(0, 0, 1'b0);

        // Randomized runs against the reference model
        for (int r = 0; r < 40; r++) begin
            n   = int'($urandom_range(0, 7));
            mgn = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 40));
            samp_q.delete();
            lat_q.delete();
            for (int k = 0; k < n; k++) begin
                samp_q.push_back(pack3(rand_lane(), rand_lane(), rand_lane()));
                lat_q.push_back(int'($urandom_range(0, 3)));
            end
            exp_q.push_back(model(n, mgn));
            do_run(n, mgn, 1'b1);
            idle = int'($urandom_range(0, 2));
            repeat (idle) begin
                @(posedge clock); #1;
            end
        end
        @(posedge clock); #1;

        // T5: start while busy is ignored; reset mid-WAIT clears everything at once
        iter_num = ITW'(5);
        margin   = '0;
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("t5_clear_pulse", longint'(layer_reset), 1);
        @(posedge clock); #1;
        check("t5_wait_busy", longint'(busy), 1);
        start        = 1'b1;
        iter_num     = '0;
        sample_valid = 1'b1;
        SampleData   = pack3(1, 2, 3);
        @(posedge clock); #1;
        start        = 1'b0;
        sample_valid = 1'b0;
        check("t5_accum_output", longint'(OutputData), longint'(pack3(1, 2, 3)));
        check("t5_accum_count", longint'(iter_count), 1);
        check("t5_busy_start_ignored", longint'(busy), 1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("t5_second_wait", longint'(busy), 1);
        #1;
        reset = 1'b1;
        #1;
        check("t5_rst_output", longint'(OutputData), 0);
        check("t5_rst_count", longint'(iter_count), 0);
        check("t5_rst_winner", longint'(winner), 0);
        check("t5_rst_early", longint'(early_stop), 0);
        check("t5_rst_finish", longint'(finish), 0);
        check("t5_rst_busy", longint'(busy), 0);
        check("t5_rst_layer_reset", longint'(layer_reset), 1);
        @(posedge clock); #1;
        check("t5_rst_layer_reset_held", longint'(layer_reset), 1);
        reset = 1'b0;
        #1;
        check("t5_post_layer_reset", longint'(layer_reset), 0);
        repeat (3) @(posedge clock);
        #1;
        check("pending_expectations", longint'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
